edge_det_multi: RTL and testbench
=================================

Name: edge_det_multi

Overview:
Parametrised multi-channel edge detector. It is the successor to the single-channel pos_edge_det, which has ports sig, clk and pe.
Per channel it provides:
- an input synchroniser;
- a glitch filter;
- rise, fall or both-edge detection selected by a per-channel mode;
- sticky flags with write-1-to-clear;
- saturating event counters.
It sits between asynchronous external status lines and the control/interrupt logic.

Parameters:
N_CH, 4, number of independent channels
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
FILT_CYCLES, 3, consecutive stable synchronised samples needed to accept a new level (>=1)
CNT_W, 8, width of each per-channel event counter

Ports:
clk  input  1  clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
sig  input  N_CH  asynchronous input lines, one bit per channel
mode  input  2*N_CH  per-channel mode, ch i = mode[2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
clr  input  N_CH  per-channel write-1-to-clear pulse for flag and cnt
pe  output  N_CH  one-cycle pulse on accepted rising edge (ignores mode)
ne  output  N_CH  one-cycle pulse on accepted falling edge (ignores mode)
evt  output  N_CH  one-cycle pulse on an accepted edge that matches mode
flag  output  N_CH  sticky event flag
cnt  output  N_CH*CNT_W  per-channel event count, ch i = cnt[CNT_W*i +: CNT_W]
irq  output  1  OR of all flag bits, registered

Behaviour:
- Reset (rst_n low, asynchronous): the following clear to 0 immediately.
  - Outputs: pe, ne, evt, flag, cnt, irq.
  - Internal state: synchroniser chains, filtered level filt, filter counters.
- Channels are fully independent; a per-channel description follows.
- Synchroniser: SYNC_STAGES-flop shift chain; its output is s.
- Filter:
  - Counter fc of width ceil(log2(FILT_CYCLES+1)).
  - If s == filt: fc <= 0.
  - If s != filt and fc == FILT_CYCLES-1: filt <= s and fc <= 0.
  - Otherwise fc <= fc+1.
  - A pulse at s shorter than FILT_CYCLES cycles is discarded; fc clears on the first cycle s returns to filt.
- Latency: let edge 1 be the first clk edge that samples sig at its new value.
  - s changes at edge SYNC_STAGES.
  - filt changes at edge SYNC_STAGES+FILT_CYCLES (edge 5 with defaults).
- pe, ne, evt: registered and asserted for exactly one cycle, starting at the same edge filt changes.
  - pe on 0->1 of filt; ne on 1->0 of filt.
  - evt = (pe & mode[0]) | (ne & mode[1]); mode 00 gives no evt.
- Mode: sampled at the edge where filt changes. A mode change takes effect from the next edge; no retroactive events.
- flag:
  - Set on evt.
  - Cleared on clr when no evt occurs in the same cycle.
  - If clr and evt coincide, flag = 1.
- cnt:
  - On evt, cnt increments, saturating at 2^CNT_W-1 (no wrap).
  - On clr, cnt <= 0.
  - If clr and evt coincide, cnt <= 1 (clear applied first, then count).
  - clr with no event pending is harmless.
- irq: registered OR of the next-state flag values, so irq rises on the same edge as the flag it reflects.
- Reset release: filt = 0. A sig held high through reset is reported as a rising edge (pe, and evt if the mode has the rise bit set) SYNC_STAGES+FILT_CYCLES edges after release. This behaviour is intended.
- Reset mid-operation: all in-flight filter and synchroniser state is discarded; no partial pulse is emitted.
- Bandwidth: the minimum spacing between accepted edges on one channel is FILT_CYCLES cycles. Edges closer than that are filtered, not queued.

Test Plan:
1. Reset: rst_n=0 with sig=4'hF. All outputs are 0 asynchronously, without a clock edge.
   Release with mode=all 01. pe=4'hF, evt=4'hF, flag=4'hF and irq=1 at edge 5; cnt per channel = 1.
2. Latency and pulse width, ch0, mode=01: sig[0] 0->1, held 20 cycles.
   - pe[0] is high only in the cycle after edge 5, and evt[0] with it.
   - ne[0]=0 and no evt on the later fall.
   - Then mode=11, sig[0] 1->0: ne[0] and evt[0] pulse at edge 5; cnt ch0 = 2.
3. Glitch rejection, defaults: sig[1] high for 2 cycles, then low. No pe, ne, evt or flag; cnt ch1 stays 0.
   Repeat with 3 high cycles: pe[1] pulses once, then ne[1] pulses 3 cycles later.
4. Saturation, CNT_W=3, mode=11: apply 10 filtered toggles on ch2.
   cnt ch2 counts 1..7 and then holds at 7; flag[2]=1 throughout.
5. Clear collision: with flag[3]=1 and cnt ch3=5, assert clr[3] in the same cycle evt[3] pulses.
   Result: flag[3]=1, cnt ch3=1. clr[3] alone on the next cycle gives flag[3]=0 and cnt ch3=0; irq drops if no other flag is set.
6. Mode off and mid-operation reset:
   - mode ch0=00 with toggling sig[0]: pe/ne pulse, evt, flag and cnt stay 0.
   - Assert rst_n low 2 cycles after a sig edge, before filt updates: no pulse ever emerges for that edge.

Source files
------------

// File: rtl/edge_det_multi.sv
// edge_det_multi: per-channel synchronised, glitch-filtered edge detector with
// mode-selected events, sticky w1c flags, saturating counters and an irq.
module edge_det_multi #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_CYCLES = 3,
  parameter int CNT_W       = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       sig,
  input  logic [2*N_CH-1:0]     mode,
  input  logic [N_CH-1:0]       clr,
  output logic [N_CH-1:0]       pe,
  output logic [N_CH-1:0]       ne,
  output logic [N_CH-1:0]       evt,
  output logic [N_CH-1:0]       flag,
  output logic [N_CH*CNT_W-1:0] cnt,
  output logic                  irq
);
  localparam int FW = $clog2(FILT_CYCLES + 1);
  localparam logic [FW-1:0] FMAX = FW'(FILT_CYCLES - 1);
  logic [N_CH-1:0] flag_nx;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sy;
    logic [FW-1:0]          fc;
    logic                   filt, s, acc, pe_nx, ne_nx, evt_nx, p, n, e, f;
    logic [CNT_W-1:0]       c;
    assign s       = sy[SYNC_STAGES-1];
    assign acc     = (s != filt) && (fc == FMAX);
    assign pe_nx   = acc & s;
    assign ne_nx   = acc & ~s;
    assign evt_nx  = (pe_nx & mode[2*i]) | (ne_nx & mode[2*i+1]);
    assign flag_nx[i] = evt_nx | (f & ~clr[i]);
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sy   <= '0;
        fc   <= '0;
        filt <= 1'b0;
        p    <= 1'b0;
        n    <= 1'b0;
        e    <= 1'b0;
        f    <= 1'b0;
        c    <= '0;
      end else begin
        sy   <= {sy[SYNC_STAGES-2:0], sig[i]};
        fc   <= (s == filt || acc) ? '0 : fc + 1'b1;
        filt <= acc ? s : filt;
        p    <= pe_nx;
        n    <= ne_nx;
        e    <= evt_nx;
        f    <= flag_nx[i];
        // clear wins first, so a coinciding event leaves a count of one
        c    <= clr[i] ? CNT_W'(evt_nx) : (evt_nx && c != '1) ? c + 1'b1 : c;
      end
    end
    assign pe[i]   = p;
    assign ne[i]   = n;
    assign evt[i]  = e;
    assign flag[i] = f;
    assign cnt[CNT_W*i +: CNT_W] = c;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= |flag_nx;
  end
endmodule

// File: tb/tb_edge_det_multi.sv
// tb_edge_det_multi: directed checks of edge_det_multi with CNT_W=3.
module tb_edge_det_multi;
  localparam int N = 4;
  localparam int W = 3;
  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   sig, clr, pe, ne, evt, flag;
  logic [2*N-1:0] mode;
  logic [N*W-1:0] cnt;
  logic           irq;
  int             n_run = 0, n_fail = 0;

  edge_det_multi #(.N_CH(N), .SYNC_STAGES(2), .FILT_CYCLES(3), .CNT_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .sig(sig), .mode(mode), .clr(clr),
    .pe(pe), .ne(ne), .evt(evt), .flag(flag), .cnt(cnt), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] cch(input int i);
    return cnt[W*i +: W];
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; sig = 4'hF; mode = 8'h55; clr = 4'h0;
    tk(3);
    chk("rst_flag", flag, 0);
    chk("rst_cnt", cnt, 0);
    rst_n = 1'b1;
    tk(4);
    chk("rel_pe_e4", pe, 4'h0);
    tk(1);
    chk("rel_pe", pe, 4'hF);
    chk("rel_evt", evt, 4'hF);
    chk("rel_flag", flag, 4'hF);
    chk("rel_irq", irq, 1);
    chk("rel_cnt", cnt, 12'h249);
    tk(1);
    chk("rel_pe_end", pe, 4'h0);
    chk("rel_flag_hold", flag, 4'hF);
    #2 rst_n = 1'b0;
    #1;
    chk("async_pe", pe, 0);
    chk("async_flag", flag, 0);
    chk("async_cnt", cnt, 0);
    chk("async_irq", irq, 0);
    sig = 4'h0;
    tk(2);
    rst_n = 1'b1;
    tk(8);
    chk("idle_pe", pe, 0);
    // latency and pulse width on ch0
    mode = 8'h01; sig[0] = 1'b1;
    tk(4);
    chk("lat_pe_e4", pe, 0);
    tk(1);
    chk("lat_pe", pe, 4'h1);
    chk("lat_evt", evt, 4'h1);
    chk("lat_ne", ne, 0);
    chk("lat_cnt0", cch(0), 1);
    chk("lat_irq", irq, 1);
    tk(1);
    chk("lat_pe_off", pe, 0);
    chk("lat_evt_off", evt, 0);
    tk(14);
    sig[0] = 1'b0;
    tk(5);
    chk("fall_ne", ne, 4'h1);
    chk("fall_evt_rise_mode", evt, 0);
    chk("fall_cnt0", cch(0), 1);
    mode = 8'h00; sig[0] = 1'b1;
    tk(8);
    chk("off_rise_cnt0", cch(0), 1);
    mode = 8'h03; sig[0] = 1'b0;
    tk(5);
    chk("both_ne", ne, 4'h1);
    chk("both_evt", evt, 4'h1);
    chk("both_cnt0", cch(0), 2);
    // glitch rejection on ch1
    mode = 8'h0F; sig[1] = 1'b1;
    tk(2);
    sig[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tk(1);
      chk("glitch_pulse", {pe[1], ne[1], evt[1]}, 0);
    end
    chk("glitch_flag1", flag[1], 0);
    chk("glitch_cnt1", cch(1), 0);
    sig[1] = 1'b1;
    tk(3);
    sig[1] = 1'b0;
    tk(2);
    chk("f3_pe", pe, 4'h2);
    chk("f3_cnt1", cch(1), 1);
    tk(3);
    chk("f3_ne", ne, 4'h2);
    chk("f3_cnt1b", cch(1), 2);
    tk(1);
    chk("f3_ne_off", ne, 0);
    // saturation on ch2
    mode = 8'h3F;
    for (int k = 1; k <= 10; k++) begin
      sig[2] = ~sig[2];
      tk(5);
      chk("sat_evt2", evt[2], 1);
      chk("sat_cnt2", cch(2), (k > 7) ? 7 : k);
      chk("sat_flag2", flag[2], 1);
    end
    clr = 4'h7;
    tk(1);
    clr = 4'h0;
    chk("clr_flags", flag, 0);
    chk("clr_cnt", cnt, 0);
    // clear collision on ch3
    mode = 8'hFF;
    for (int k = 1; k <= 5; k++) begin
      sig[3] = ~sig[3];
      tk(5);
    end
    chk("col_pre_cnt3", cch(3), 5);
    chk("col_pre_flag3", flag[3], 1);
    sig[3] = 1'b0;
    tk(4);
    clr = 4'h8;
    tk(1);
    chk("col_evt3", evt[3], 1);
    chk("col_flag3", flag[3], 1);
    chk("col_cnt3", cch(3), 1);
    tk(1);
    clr = 4'h0;
    chk("w1c_flag3", flag[3], 0);
    chk("w1c_cnt3", cch(3), 0);
    chk("w1c_irq", irq, 0);
    // mode off on ch0
    mode = 8'hFC; sig[0] = 1'b1;
    tk(5);
    chk("off_pe", pe, 4'h1);
    chk("off_evt", evt, 0);
    sig[0] = 1'b0;
    tk(5);
    chk("off_ne", ne, 4'h1);
    chk("off_evt_f", evt, 0);
    chk("off_flag", flag, 0);
    chk("off_cnt0", cch(0), 0);
    // reset before the filter accepts the edge
    mode = 8'hFF; sig[0] = 1'b1;
    tk(2);
    rst_n = 1'b0; sig[0] = 1'b0;
    tk(1);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tk(1);
      chk("midrst_pulse", {pe, ne, evt}, 0);
    end
    chk("midrst_flag", flag, 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
